ws2812_receiver: RTL and testbench
==================================

# ws2812_receiver

Decodes a single-wire WS2812 bit stream, as produced by the team's WS2812 bit driver, back into 24-bit GRB pixel words. It classifies each high pulse by width, assembles pixels MSB-first and detects the frame reset (long low). It delivers pixels over a valid/ready handshake. Used as a bench monitor for the driver, and as a front end for daisy-chain and loop-back designs.

## Interface
- `BIT_THRESH`, 10'd4: a high-pulse length ≥ this many cycles decodes as '1'; shorter decodes as '0'.
- `RESET_LEN`, 10'd50: consecutive low cycles that mark a frame reset.
- `COUNTER_W`, 10: width of the pulse counter. Must satisfy 2^COUNTER_W-1 ≥ RESET_LEN.
- `clk_in`, input, 1: clock.
- `rst_n_in`, input, 1: reset, asynchronous, active-low.
- `ws2812_in`, input, 1: raw serial line, asynchronous to `clk_in`.
- `pixel_out`, output, 24: decoded pixel, bit 23 first on the wire.
- `pixel_out_valid`, output, 1: `pixel_out` holds an unconsumed pixel.
- `pixel_out_ready`, input, 1: consumer accepts the pixel.
- `frame_end_out`, output, 1: one-cycle pulse on detection of a frame reset.
- `err_out`, output, 1: one-cycle pulse on a protocol error (partial pixel, over-long high, or overflow).
- `ws2812_fwd_out`, output, 1: forwarded line (see Configuration).

## Operation
- `ws2812_in` passes through a 2-flop synchronizer to give `ws_s`. A registered copy `ws_q` provides edge detection:
  - rise = `ws_s & ~ws_q`
  - fall = `~ws_s & ws_q`
- Reset value of every output is 0. The reset state is S_WAIT_RST, with all counters and the shift register cleared.
- S_WAIT_RST
  - Counts consecutive cycles with `ws_s`=0; the count clears whenever `ws_s`=1.
  - When the count reaches RESET_LEN, go to S_IDLE. `frame_end_out` is not pulsed.
  - This prevents locking onto the middle of a frame.
- S_IDLE: on rise, load `cnt`=1 and go to S_HIGH.
- S_HIGH
  - While `ws_s`=1, `cnt` increments.
  - If `cnt` reaches RESET_LEN: pulse `err_out`, discard the partial pixel, go to S_WAIT_RST.
  - On fall: the decoded bit is (`cnt` ≥ BIT_THRESH). Shift it into `shift[23:0]` at bit 0, increment `bit_cnt`, load `cnt`=1, go to S_LOW.
- S_LOW
  - On rise: load `cnt`=1, go to S_HIGH.
  - Otherwise `cnt` increments.
  - When `cnt` reaches RESET_LEN: pulse `frame_end_out` and go to S_IDLE.
  - If `bit_cnt`≠0 at that point, also pulse `err_out` and clear `bit_cnt` and `shift`.
- Pixel completion
  - When the 24th bit is shifted in, `bit_cnt` wraps to 0.
  - If the output slot is free, or is being accepted this cycle (`pixel_out_valid & pixel_out_ready`), load `pixel_out` and set `pixel_out_valid`.
  - Otherwise, keep the old pixel, drop the new one, and pulse `err_out`.
- Handshake
  - `pixel_out_valid` stays high and `pixel_out` stays stable until `pixel_out_ready` is sampled high.
  - Accepting with no simultaneous completion clears `valid` on the next edge.
- `cnt` never exceeds RESET_LEN. Comparisons are unsigned at COUNTER_W bits.

## Timing
- A raw edge first sampled at clock edge N is seen as rise/fall between edges N+1 and N+2. A high pulse of H raw cycles yields `cnt`=H at fall.
- Last falling edge of pixel sampled at edge N → `pixel_out_valid`=1 after edge N+2.
- Last low cycle completing RESET_LEN → `frame_end_out` high for exactly the following cycle.
- Consecutive pixels need no idle gap. Throughput is limited only by the line and by `pixel_out_ready`.
- Asserting `rst_n_in` mid-frame clears everything asynchronously and restarts in S_WAIT_RST.

## Configuration
- Macro `WS2812_FWD_EN` defined:
  - A `pass` flag sets when the first pixel of a frame completes and clears at frame end or error.
  - `ws2812_fwd_out` is registered as `pass & ws_s`. This regenerates the stream minus its first 24 bits, delayed by 3 cycles, as a WS2812 LED does on its DOUT.
- Macro `WS2812_FWD_EN` undefined: `ws2812_fwd_out` is constant 0 and no `pass` logic is built.

## Test plan
- Reset, hold line low for 60 cycles, then send 24 bits of 0xA5C3F0 ('0' = 2 high/6 low, '1' = 6 high/2 low), then 60 low with ready=1 → `pixel_out`=0xA5C3F0 with a single valid pulse, followed by one `frame_end_out` pulse and no `err_out`.
- Pulses of exactly 3 and 4 high cycles with BIT_THRESH=4 → decoded bits 0 and 1 respectively.
- Two back-to-back pixels 0x000001 and 0xFFFFFF with ready=0 → first held and stable, second dropped with one `err_out` pulse. Raising ready then yields exactly one transfer.
- Frame starts mid-pixel without a preceding 50-cycle low → nothing is decoded until 50 low cycles are seen. A 12-bit pixel followed by reset low → `frame_end_out` and `err_out` both pulse, and no valid is asserted.
- Line held high for 50 cycles → `err_out` pulse, and no valid until a fresh reset low and a full pixel arrive.
- With `WS2812_FWD_EN`, send 3 pixels → `ws2812_fwd_out` stays 0 during pixel 1, then reproduces pixels 2–3 waveforms 3 cycles late, then returns to 0.

Source files
------------

// File: rtl/ws2812_receiver_if.sv
// Pixel delivery bundle of the WS2812 receiver: valid/ready pixel channel plus
// the frame-end and error event pulses.
interface ws2812_receiver_if;
    logic [23:0] pixel_out;
    logic        pixel_out_valid;
    logic        pixel_out_ready;
    logic        frame_end_out;
    logic        err_out;

    modport master (
        output pixel_out,
        output pixel_out_valid,
        input  pixel_out_ready,
        output frame_end_out,
        output err_out
    );

    modport slave (
        input  pixel_out,
        input  pixel_out_valid,
        output pixel_out_ready,
        input  frame_end_out,
        input  err_out
    );
endinterface

// File: rtl/ws2812_receiver.sv
// WS2812 single-wire decoder: pulse-width bit classification, MSB-first GRB pixel
// assembly, frame-reset detection. Optional line forwarding under WS2812_FWD_EN.
module ws2812_receiver #(
    parameter int unsigned              COUNTER_W  = 10,
    parameter logic [COUNTER_W-1:0]     BIT_THRESH = COUNTER_W'(4),
    parameter logic [COUNTER_W-1:0]     RESET_LEN  = COUNTER_W'(50)
) (
    input  logic                       clk_in,
    input  logic                       rst_n_in,
    input  logic                       ws2812_in,
    output logic                       ws2812_fwd_out,
    ws2812_receiver_if.master          pixel_bus
);

    typedef enum logic [1:0] {
        S_WAIT_RST,
        S_IDLE,
        S_HIGH,
        S_LOW
    } state_t;

    localparam logic [COUNTER_W-1:0] CNT_ONE = COUNTER_W'(1);

    logic ws_m, ws_s, ws_q;
    logic rise, fall;

    state_t                state, state_n;
    logic [COUNTER_W-1:0]  cnt, cnt_n;
    logic [4:0]            bit_cnt, bit_cnt_n;
    logic [23:0]           shift, shift_n;
    logic [23:0]           pixel_n;
    logic                  valid_n;
    logic                  frame_end_n;
    logic                  err_n;
    logic                  complete;
    logic                  load;

    // NOTE: ws_m may go metastable; only ws_s and later stages feed any logic.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            ws_m <= 1'b0;
            ws_s <= 1'b0;
            ws_q <= 1'b0;
        end else begin
            ws_m <= ws2812_in;
            ws_s <= ws_m;
            ws_q <= ws_s;
        end
    end

    assign rise = ws_s & ~ws_q;
    assign fall = ~ws_s & ws_q;

    // NOTE: every signal written below gets a default first, so no path can infer a latch.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        bit_cnt_n   = bit_cnt;
        shift_n     = shift;
        frame_end_n = 1'b0;
        err_n       = 1'b0;
        complete    = 1'b0;

        case (state)
            S_WAIT_RST: begin
                if (ws_s) begin
                    cnt_n = '0;
                end else if (cnt == RESET_LEN - CNT_ONE) begin
                    cnt_n   = '0;
                    state_n = S_IDLE;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            S_IDLE: begin
                if (rise) begin
                    cnt_n   = CNT_ONE;
                    state_n = S_HIGH;
                end
            end
            S_HIGH: begin
                // A high that lasts a full reset length is not a bit: resync.
                if (cnt >= RESET_LEN) begin
                    err_n     = 1'b1;
                    cnt_n     = '0;
                    bit_cnt_n = '0;
                    shift_n   = '0;
                    state_n   = S_WAIT_RST;
                end else if (fall) begin
                    shift_n = {shift[22:0], (cnt >= BIT_THRESH)};
                    if (bit_cnt == 5'd23) begin
                        bit_cnt_n = '0;
                        complete  = 1'b1;
                    end else begin
                        bit_cnt_n = bit_cnt + 5'd1;
                    end
                    cnt_n   = CNT_ONE;
                    state_n = S_LOW;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            S_LOW: begin
                if (rise) begin
                    cnt_n   = CNT_ONE;
                    state_n = S_HIGH;
                end else if (cnt >= RESET_LEN) begin
                    frame_end_n = 1'b1;
                    cnt_n       = '0;
                    state_n     = S_IDLE;
                    if (bit_cnt != 5'd0) begin
                        err_n     = 1'b1;
                        bit_cnt_n = '0;
                        shift_n   = '0;
                    end
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            default: begin
                state_n = S_WAIT_RST;
            end
        endcase

        // Output slot: a finished pixel may replace one that is leaving this cycle.
        load    = complete & (~pixel_bus.pixel_out_valid | pixel_bus.pixel_out_ready);
        pixel_n = pixel_bus.pixel_out;
        valid_n = pixel_bus.pixel_out_valid;
        if (load) begin
            pixel_n = shift_n;
            valid_n = 1'b1;
        end else if (pixel_bus.pixel_out_valid & pixel_bus.pixel_out_ready) begin
            valid_n = 1'b0;
        end
        if (complete & ~load) begin
            err_n = 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state                     <= S_WAIT_RST;
            cnt                       <= '0;
            bit_cnt                   <= '0;
            shift                     <= '0;
            pixel_bus.pixel_out       <= '0;
            pixel_bus.pixel_out_valid <= 1'b0;
            pixel_bus.frame_end_out   <= 1'b0;
            pixel_bus.err_out         <= 1'b0;
        end else begin
            state                     <= state_n;
            cnt                       <= cnt_n;
            bit_cnt                   <= bit_cnt_n;
            shift                     <= shift_n;
            pixel_bus.pixel_out       <= pixel_n;
            pixel_bus.pixel_out_valid <= valid_n;
            pixel_bus.frame_end_out   <= frame_end_n;
            pixel_bus.err_out         <= err_n;
        end
    end

`ifdef WS2812_FWD_EN
    // Forward everything after the first pixel of the frame, like an LED's DOUT.
    logic pass;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            pass           <= 1'b0;
            ws2812_fwd_out <= 1'b0;
        end else begin
            pass           <= (pass | complete) & ~frame_end_n & ~err_n;
            ws2812_fwd_out <= pass & ws_s;
        end
    end
`else
    assign ws2812_fwd_out = 1'b0;
`endif

endmodule

// File: tb/tb_ws2812_receiver.sv
// Self-checking bench for ws2812_receiver: randomized pulse trains checked against
// a pulse-width decoding model; forwarding checked when WS2812_FWD_EN is defined.
module tb_ws2812_receiver;

    localparam int THRESH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ws = 1'b0;
    logic fwd;

    ws2812_receiver_if bus ();

    ws2812_receiver dut (
        .clk_in         (clk),
        .rst_n_in       (rst_n),
        .ws2812_in      (ws),
        .ws2812_fwd_out (fwd),
        .pixel_bus      (bus.master)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    int          fe_cnt = 0;
    int          err_cnt = 0;
    int          stab_bad = 0;
    logic [23:0] got_q[$];
    logic        prev_hold = 1'b0;
    logic [23:0] prev_px = '0;

    // Observer: transfers, event pulses and hold-stability of the pixel slot.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold && (bus.pixel_out_valid !== 1'b1 || bus.pixel_out !== prev_px)) stab_bad++;
            if (bus.pixel_out_valid && bus.pixel_out_ready) got_q.push_back(bus.pixel_out);
            if (bus.frame_end_out) fe_cnt++;
            if (bus.err_out) err_cnt++;
            prev_hold = bus.pixel_out_valid && !bus.pixel_out_ready;
            prev_px   = bus.pixel_out;
        end
    end

    task automatic drive(input logic lvl, input int n);
        repeat (n) begin
            @(posedge clk);
            #1 ws = lvl;
        end
    endtask

    task automatic send_pulse(input int h, input int l);
        drive(1'b1, h);
        drive(1'b0, l);
    endtask

    task automatic send_bits(input logic [23:0] px, input int nbits);
        for (int i = 23; i > 23 - nbits; i--) begin
            if (px[i]) send_pulse(6, 2);
            else       send_pulse(2, 6);
        end
    endtask

    // Reference: each high pulse is a bit (long enough => 1), 24 bits per pixel, MSB first.
    function automatic logic [23:0] model_pixel(input int hs[$], input int base);
        logic [23:0] p = '0;
        for (int k = 0; k < 24; k++) p = {p[22:0], (hs[base + k] >= THRESH)};
        return p;
    endfunction

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        total++; if (bus.pixel_out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus.pixel_out_valid); end
        total++; if (bus.pixel_out !== 24'h0) begin bad++; $display("FAIL reset_pixel: got %h want 000000", bus.pixel_out); end
        total++; if (bus.frame_end_out !== 1'b0) begin bad++; $display("FAIL reset_frame_end: got %b want 0", bus.frame_end_out); end
        total++; if (bus.err_out !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", bus.err_out); end
        total++; if (fwd !== 1'b0) begin bad++; $display("FAIL reset_fwd: got %b want 0", fwd); end
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int fe0, err0, got0;
        fe0 = fe_cnt; err0 = err_cnt; got0 = got_q.size();
        bus.pixel_out_ready = 1'b1;
        drive(1'b0, 60);
        send_bits(24'hA5C3F0, 24);
        drive(1'b0, 60);
        total++; if (got_q.size() - got0 !== 1) begin bad++; $display("FAIL basic_count: got %0d want 1", got_q.size() - got0); end
        total++; if (got_q.size() > got0 && got_q[got0] !== 24'hA5C3F0) begin bad++; $display("FAIL basic_pixel: got %h want a5c3f0", got_q[got0]); end
        total++; if (fe_cnt - fe0 !== 1) begin bad++; $display("FAIL basic_frame_end: got %0d want 1", fe_cnt - fe0); end
        total++; if (err_cnt - err0 !== 0) begin bad++; $display("FAIL basic_err: got %0d want 0", err_cnt - err0); end
    endtask

    task automatic test_threshold();
        int hs[$];
        int fe0, err0, got0;
        int npix = 4;
        fe0 = fe_cnt; err0 = err_cnt; got0 = got_q.size();
        for (int k = 0; k < 24; k++) hs.push_back((k % 2 == 0) ? 3 : 4);
        for (int k = 24; k < 24 * npix; k++) hs.push_back(int'($urandom_range(8, 1)));
        for (int k = 0; k < 24 * npix; k++) send_pulse(hs[k], int'($urandom_range(6, 2)));
        drive(1'b0, 60);
        total++; if (got_q.size() - got0 !== npix) begin bad++; $display("FAIL thresh_count: got %0d want %0d", got_q.size() - got0, npix); end
        for (int p = 0; p < npix; p++) begin
            if (got0 + p < got_q.size()) begin
                total++;
                if (got_q[got0 + p] !== model_pixel(hs, 24 * p)) begin
                    bad++; $display("FAIL thresh_pixel%0d: got %h want %h", p, got_q[got0 + p], model_pixel(hs, 24 * p));
                end
            end
        end
        total++; if (fe_cnt - fe0 !== 1) begin bad++; $display("FAIL thresh_frame_end: got %0d want 1", fe_cnt - fe0); end
        total++; if (err_cnt - err0 !== 0) begin bad++; $display("FAIL thresh_err: got %0d want 0", err_cnt - err0); end
    endtask

    task automatic test_back_to_back();
        int fe0, err0, got0, stab0;
        fe0 = fe_cnt; err0 = err_cnt; got0 = got_q.size(); stab0 = stab_bad;
        @(posedge clk);
        #1 bus.pixel_out_ready = 1'b0;
        send_bits(24'h000001, 24);
        send_bits(24'hFFFFFF, 24);
        drive(1'b0, 60);
        @(negedge clk);
        total++; if (bus.pixel_out_valid !== 1'b1) begin bad++; $display("FAIL b2b_held_valid: got %b want 1", bus.pixel_out_valid); end
        total++; if (bus.pixel_out !== 24'h000001) begin bad++; $display("FAIL b2b_held_pixel: got %h want 000001", bus.pixel_out); end
        total++; if (err_cnt - err0 !== 1) begin bad++; $display("FAIL b2b_err: got %0d want 1", err_cnt - err0); end
        total++; if (fe_cnt - fe0 !== 1) begin bad++; $display("FAIL b2b_frame_end: got %0d want 1", fe_cnt - fe0); end
        total++; if (got_q.size() - got0 !== 0) begin bad++; $display("FAIL b2b_early_xfer: got %0d want 0", got_q.size() - got0); end
        total++; if (stab_bad - stab0 !== 0) begin bad++; $display("FAIL b2b_stability: got %0d unstable cycles want 0", stab_bad - stab0); end
        @(posedge clk);
        #1 bus.pixel_out_ready = 1'b1;
        @(posedge clk);
        #1 bus.pixel_out_ready = 1'b0;
        drive(1'b0, 5);
        total++; if (got_q.size() - got0 !== 1) begin bad++; $display("FAIL b2b_xfer_count: got %0d want 1", got_q.size() - got0); end
        total++; if (got_q.size() > got0 && got_q[got0] !== 24'h000001) begin bad++; $display("FAIL b2b_xfer_pixel: got %h want 000001", got_q[got0]); end
        @(negedge clk);
        total++; if (bus.pixel_out_valid !== 1'b0) begin bad++; $display("FAIL b2b_valid_cleared: got %b want 0", bus.pixel_out_valid); end
        bus.pixel_out_ready = 1'b1;
    endtask

    task automatic test_midframe();
        int fe0, err0, got0;
        logic [23:0] px;
        @(posedge clk);
        #1 rst_n = 1'b0; ws = 1'b0;
        drive(1'b0, 2);
        rst_n = 1'b1;
        fe0 = fe_cnt; err0 = err_cnt; got0 = got_q.size();
        drive(1'b0, 3);
        send_bits(24'($urandom), 24);
        drive(1'b0, 60);
        total++; if (got_q.size() - got0 !== 0) begin bad++; $display("FAIL mid_locked_early: got %0d pixels want 0", got_q.size() - got0); end
        total++; if (fe_cnt - fe0 !== 0) begin bad++; $display("FAIL mid_sync_frame_end: got %0d want 0", fe_cnt - fe0); end
        send_bits(24'($urandom), 12);
        drive(1'b0, 60);
        total++; if (fe_cnt - fe0 !== 1) begin bad++; $display("FAIL mid_partial_frame_end: got %0d want 1", fe_cnt - fe0); end
        total++; if (err_cnt - err0 !== 1) begin bad++; $display("FAIL mid_partial_err: got %0d want 1", err_cnt - err0); end
        total++; if (got_q.size() - got0 !== 0) begin bad++; $display("FAIL mid_partial_valid: got %0d want 0", got_q.size() - got0); end
        px = 24'($urandom);
        send_bits(px, 24);
        drive(1'b0, 60);
        total++; if (got_q.size() - got0 !== 1) begin bad++; $display("FAIL mid_recover_count: got %0d want 1", got_q.size() - got0); end
        total++; if (got_q.size() > got0 && got_q[got0] !== px) begin bad++; $display("FAIL mid_recover_pixel: got %h want %h", got_q[got0], px); end
        total++; if (err_cnt - err0 !== 1) begin bad++; $display("FAIL mid_recover_err: got %0d want 1", err_cnt - err0); end
    endtask

    task automatic test_long_high();
        int fe0, err0, got0;
        logic [23:0] px;
        fe0 = fe_cnt; err0 = err_cnt; got0 = got_q.size();
        drive(1'b1, 60);
        drive(1'b0, 10);
        send_bits(24'($urandom), 24);
        drive(1'b0, 60);
        total++; if (err_cnt - err0 !== 1) begin bad++; $display("FAIL long_err: got %0d want 1", err_cnt - err0); end
        total++; if (got_q.size() - got0 !== 0) begin bad++; $display("FAIL long_no_valid: got %0d want 0", got_q.size() - got0); end
        total++; if (fe_cnt - fe0 !== 0) begin bad++; $display("FAIL long_no_frame_end: got %0d want 0", fe_cnt - fe0); end
        px = 24'($urandom);
        send_bits(px, 24);
        drive(1'b0, 60);
        total++; if (got_q.size() - got0 !== 1) begin bad++; $display("FAIL long_recover_count: got %0d want 1", got_q.size() - got0); end
        total++; if (got_q.size() > got0 && got_q[got0] !== px) begin bad++; $display("FAIL long_recover_pixel: got %h want %h", got_q[got0], px); end
        total++; if (fe_cnt - fe0 !== 1) begin bad++; $display("FAIL long_recover_frame_end: got %0d want 1", fe_cnt - fe0); end
    endtask

    task automatic test_forward();
        logic raw[$];
        logic exp_fwd[$];
        logic rec[$];
        logic [23:0] px;
        int p2_start, p3_end, mism, first_bad, got0;
        got0 = got_q.size();
        for (int i = 0; i < 60; i++) raw.push_back(1'b0);
        p2_start = 0;
        for (int p = 0; p < 3; p++) begin
            px = 24'($urandom);
            if (p == 1) p2_start = raw.size();
            for (int b = 23; b >= 0; b--) begin
                int h = px[b] ? 6 : 2;
                for (int k = 0; k < 8; k++) raw.push_back(k < h);
            end
        end
        p3_end = raw.size();
        for (int i = 0; i < 70; i++) raw.push_back(1'b0);
        for (int i = 0; i < raw.size(); i++) begin
`ifdef WS2812_FWD_EN
            exp_fwd.push_back((i >= p2_start && i < p3_end) ? raw[i] : 1'b0);
`else
            exp_fwd.push_back(1'b0);
`endif
        end
        for (int i = 0; i < raw.size(); i++) begin
            @(posedge clk);
            #1 ws = raw[i];
            @(negedge clk);
            rec.push_back(fwd);
        end
        mism = 0; first_bad = -1;
        for (int i = 0; i + 3 < rec.size(); i++) begin
            if (rec[i + 3] !== exp_fwd[i]) begin
                mism++;
                if (first_bad < 0) first_bad = i;
            end
        end
        total++; if (mism !== 0) begin bad++; $display("FAIL fwd_waveform: got %0d mismatching cycles (first at line cycle %0d) want 0", mism, first_bad); end
        total++; if (got_q.size() - got0 !== 3) begin bad++; $display("FAIL fwd_pixel_count: got %0d want 3", got_q.size() - got0); end
    endtask

    initial begin
        bus.pixel_out_ready = 1'b0;
        test_reset();
        test_basic();
        test_threshold();
        test_back_to_back();
        test_midframe();
        test_long_high();
        test_forward();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
